// File: rtl/axi_burst_master_pkg.sv
// Shared AXI channel widths, protocol constants and the FSM encoding
// used by axi_burst_master and its helpers.
package axi_burst_master_pkg;

  localparam int AXI_BURST_LEN_WIDTH  = 8;
  localparam int AXI_BURST_SIZE_WIDTH = 3;
  localparam int AXI_BURST_TYPE_WIDTH = 2;
  localparam int AXI_RESP_WIDTH       = 2;
  localparam int AXI_PROT_WIDTH       = 3;
  localparam int AXI_CACHE_WIDTH      = 4;
  localparam int AXI_QOS_WIDTH        = 4;
  localparam int AXI_REGION_WIDTH     = 4;

  localparam logic [AXI_BURST_TYPE_WIDTH-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_WIDTH-1:0]       AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_e;

  // AxSIZE encoding for a full-width beat of strb_width bytes.
  function automatic logic [AXI_BURST_SIZE_WIDTH-1:0] burst_size(input int strb_width);
    return AXI_BURST_SIZE_WIDTH'($clog2(strb_width));
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// Full AXI4 channel bundle (AW/W/B/AR/R) with master and slave views.
interface axi_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  import axi_burst_master_pkg::*;

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]             awid;
  logic [ADDR_WIDTH-1:0]           awaddr;
  logic [AXI_BURST_LEN_WIDTH-1:0]  awlen;
  logic [AXI_BURST_SIZE_WIDTH-1:0] awsize;
  logic [AXI_BURST_TYPE_WIDTH-1:0] awburst;
  logic                            awlock;
  logic [AXI_CACHE_WIDTH-1:0]      awcache;
  logic [AXI_PROT_WIDTH-1:0]       awprot;
  logic [AXI_QOS_WIDTH-1:0]        awqos;
  logic [AXI_REGION_WIDTH-1:0]     awregion;
  logic                            awvalid;
  logic                            awready;

  logic [DATA_WIDTH-1:0]           wdata;
  logic [STRB_WIDTH-1:0]           wstrb;
  logic                            wlast;
  logic                            wvalid;
  logic                            wready;

  logic [ID_WIDTH-1:0]             bid;
  logic [AXI_RESP_WIDTH-1:0]       bresp;
  logic                            bvalid;
  logic                            bready;

  logic [ID_WIDTH-1:0]             arid;
  logic [ADDR_WIDTH-1:0]           araddr;
  logic [AXI_BURST_LEN_WIDTH-1:0]  arlen;
  logic [AXI_BURST_SIZE_WIDTH-1:0] arsize;
  logic [AXI_BURST_TYPE_WIDTH-1:0] arburst;
  logic                            arlock;
  logic [AXI_CACHE_WIDTH-1:0]      arcache;
  logic [AXI_PROT_WIDTH-1:0]       arprot;
  logic [AXI_QOS_WIDTH-1:0]        arqos;
  logic [AXI_REGION_WIDTH-1:0]     arregion;
  logic                            arvalid;
  logic                            arready;

  logic [ID_WIDTH-1:0]             rid;
  logic [DATA_WIDTH-1:0]           rdata;
  logic [AXI_RESP_WIDTH-1:0]       rresp;
  logic                            rlast;
  logic                            rvalid;
  logic                            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_mst_4k_check.sv
// Combinational 4 KB boundary test: flags a burst whose last byte would
// fall beyond the 4 KB page containing its start address.
module axi_mst_4k_check #(
  parameter int STRB_WIDTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [11:0]          addr_lo_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 cross_o
);

  logic [31:0] end_offset;

  // End offset within the page, computed wide enough that it never wraps.
  always_comb begin
    end_offset = 32'(addr_lo_i) + (32'(len_i) + 32'd1) * 32'(STRB_WIDTH);
    cross_o    = (end_offset > 32'd4096);
  end

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master driven by a command port,
// a write-data stream and a read-data stream.
// Optional feature: define AXI_MASTER_4K_CHECK_EN to reject commands whose
// burst would cross a 4 KB boundary (no AXI traffic, done with err=1).
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           m_axi_aclk,
  input  logic                           m_axi_aresetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr,
  input  logic [AXI_BURST_LEN_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_last,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic                           done,
  output logic                           err,
  axi_burst_master_if.master             m_axi
);

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [AXI_BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [AXI_BURST_LEN_WIDTH-1:0] beat_q, beat_d;
  logic                           err_q, err_d;
  // Holds cmd_ready low until the first clock after reset release.
  logic                           live_q;
  logic                           cross_4k;
  logic                           last_beat;
  logic                           unused_ids;

`ifdef AXI_MASTER_4K_CHECK_EN
  axi_mst_4k_check #(
    .STRB_WIDTH (STRB_WIDTH),
    .LEN_WIDTH  (AXI_BURST_LEN_WIDTH)
  ) u_4k_check (
    .addr_lo_i (cmd_addr[11:0]),
    .len_i     (cmd_len),
    .cross_o   (cross_4k)
  );
`else
  assign cross_4k = 1'b0;
`endif

  // Response IDs are not checked: only one burst is ever outstanding.
  assign unused_ids = ^{m_axi.bid, m_axi.rid};

  assign last_beat = (beat_q == len_q);

  // Address channel fields come straight from registers so they stay stable.
  assign m_axi.awid     = ID_WIDTH'(AXI_ID);
  assign m_axi.awaddr   = addr_q;
  assign m_axi.awlen    = len_q;
  assign m_axi.awsize   = burst_size(STRB_WIDTH);
  assign m_axi.awburst  = AXI_BURST_INCR;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = '0;
  assign m_axi.awprot   = '0;
  assign m_axi.awqos    = '0;
  assign m_axi.awregion = '0;
  assign m_axi.arid     = ID_WIDTH'(AXI_ID);
  assign m_axi.araddr   = addr_q;
  assign m_axi.arlen    = len_q;
  assign m_axi.arsize   = burst_size(STRB_WIDTH);
  assign m_axi.arburst  = AXI_BURST_INCR;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = '0;
  assign m_axi.arprot   = '0;
  assign m_axi.arqos    = '0;
  assign m_axi.arregion = '0;
  assign m_axi.wdata    = wr_data;
  assign m_axi.wstrb    = '1;
  assign rd_data        = m_axi.rdata;

  // State and datapath registers; reset drops every valid immediately.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state logic and all handshake outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    err_d         = err_q;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.wlast   = 1'b0;
    m_axi.bready  = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          beat_d = '0;
          err_d  = 1'b0;
          if (cross_4k) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = cmd_write ? WR_ADDR : RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        m_axi.awvalid = 1'b1;
        if (m_axi.awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        m_axi.wvalid = wr_valid;
        wr_ready     = m_axi.wready;
        m_axi.wlast  = last_beat;
        if (wr_valid && m_axi.wready) begin
          beat_d = beat_q + AXI_BURST_LEN_WIDTH'(1);
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          err_d   = (m_axi.bresp != AXI_RESP_OKAY);
          state_d = DONE;
        end
      end
      RD_ADDR: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rd_valid     = m_axi.rvalid;
        rd_last      = m_axi.rlast;
        m_axi.rready = rd_ready;
        if (m_axi.rvalid && rd_ready) begin
          beat_d = beat_q + AXI_BURST_LEN_WIDTH'(1);
          if (m_axi.rresp != AXI_RESP_OKAY) err_d = 1'b1;
          if (m_axi.rlast) begin
            state_d = DONE;
          end else if (last_beat) begin
            // Slave overran the requested length: stop and flag it.
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a small single-burst AXI RAM model.
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready = 1'b0;
  logic        done, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) m_if ();

  axi_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .AXI_ID(0)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err), .m_axi(m_if)
  );

  // ---------------- AXI RAM slave model ----------------
  logic [31:0] mem [0:1023];
  int          s_phase = 0;            // 0 idle, 1 W, 2 B, 3 R
  logic [9:0]  s_ptr = '0;
  logic [7:0]  s_len = '0, s_cnt = '0;
  logic        awready_q = 1'b0, arready_q = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        nolast_cfg = 1'b0;
  int          aw_count = 0, ar_count = 0, early_w = 0;
  logic [15:0] aw_addr_log = '0, ar_addr_log = '0;
  logic [7:0]  aw_len_log = '0, ar_len_log = '0;
  logic [2:0]  aw_size_log = '0;
  logic [1:0]  aw_burst_log = '0;
  logic [9:0]  s_idx;

  assign s_idx      = s_ptr + {2'b00, s_cnt};
  assign m_if.awready = awready_q;
  assign m_if.arready = arready_q;
  assign m_if.wready  = (s_phase == 1);
  assign m_if.bvalid  = (s_phase == 2);
  assign m_if.bresp   = bresp_cfg;
  assign m_if.bid     = '0;
  assign m_if.rvalid  = (s_phase == 3);
  assign m_if.rdata   = mem[s_idx];
  assign m_if.rlast   = (s_cnt == s_len) && !nolast_cfg;
  assign m_if.rresp   = 2'b00;
  assign m_if.rid     = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_phase <= 0; awready_q <= 1'b0; arready_q <= 1'b0; s_cnt <= '0;
    end else begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      case (s_phase)
        0: if (m_if.awvalid && awready_q) begin
             s_phase <= 1; s_ptr <= m_if.awaddr[11:2]; s_len <= m_if.awlen; s_cnt <= '0;
             aw_addr_log <= m_if.awaddr; aw_len_log <= m_if.awlen;
             aw_size_log <= m_if.awsize; aw_burst_log <= m_if.awburst;
             aw_count <= aw_count + 1;
           end else if (m_if.arvalid && arready_q) begin
             s_phase <= 3; s_ptr <= m_if.araddr[11:2]; s_len <= m_if.arlen; s_cnt <= '0;
             ar_addr_log <= m_if.araddr; ar_len_log <= m_if.arlen;
             ar_count <= ar_count + 1;
           end else begin
             // One-cycle-late ready makes the master hold its address.
             awready_q <= m_if.awvalid;
             arready_q <= m_if.arvalid && !m_if.awvalid;
           end
        1: if (m_if.wvalid) begin
             mem[s_idx] <= m_if.wdata;
             s_cnt <= s_cnt + 8'd1;
             if (m_if.wlast) s_phase <= 2;
           end
        2: if (m_if.bready) s_phase <= 0;
        3: if (m_if.rready) begin
             s_cnt <= s_cnt + 8'd1;
             if (s_cnt == s_len) s_phase <= 0;
           end
        default: s_phase <= 0;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Done pulse monitor: counts cycles with done high.
  int   done_cycles = 0;
  int   done_base = 0;
  logic err_at_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      done_cycles <= done_cycles + 1;
      err_at_done <= err;
    end
  end

  // W must never appear before the AW handshake.
  always @(negedge clk) begin
    if (rst_n && m_if.wvalid && s_phase != 1) early_w <= early_w + 1;
  end

  // Address valid and address must hold while the slave stalls.
  logic        aw_pend = 1'b0;
  logic [15:0] aw_prev = '0;
  always @(negedge clk) begin
    if (rst_n && aw_pend) check("aw_hold", {15'd0, m_if.awvalid, m_if.awaddr}, {15'd0, 1'b1, aw_prev});
    aw_pend <= rst_n && m_if.awvalid && !m_if.awready;
    aw_prev <= m_if.awaddr;
  end

  logic [31:0] wq [0:255];

  task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    done_base = done_cycles;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_stream(input int n, input logic toggle);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 3000) begin
      wr_valid = !toggle || (cyc % 2 == 0);
      wr_data  = wq[i];
      #1;
      if (wr_valid && wr_ready) begin
        check("wlast", {31'd0, m_if.wlast}, {31'd0, i == n - 1});
        check("wdata", m_if.wdata, wq[i]);
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    check("w_beats_sent", i, n);
  endtask

  task automatic read_stream(input int n, input logic stall, input logic last_en);
    int i = 0;
    int cyc = 0;
    int hold = 0;
    logic [31:0] held = '0;
    while (i < n && cyc < 3000) begin
      rd_ready = !stall || (hold == 3);
      #1;
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, wq[i]);
        check("rd_last", {31'd0, rd_last}, {31'd0, last_en && (i == n - 1)});
        i++;
        hold = 0;
      end else if (rd_valid) begin
        if (hold > 0) check("rd_hold", rd_data, held);
        held = rd_data;
        hold++;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    check("r_beats_seen", i, n);
  endtask

  task automatic wait_done(input string tag, input logic want_err, output int lat);
    int t = 0;
    while (done_cycles == done_base && t < 600) begin @(negedge clk); t++; end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_pulses"}, done_cycles - done_base, 1);
    check({tag, "_err"}, {31'd0, err_at_done}, {31'd0, want_err});
    lat = t;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int i;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_valids", {28'd0, m_if.awvalid, m_if.wvalid, m_if.arvalid, rd_valid}, 32'd0);
    check("rst_readies", {29'd0, m_if.bready, m_if.rready, wr_ready}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    rst_n = 1'b1;
    #1 check("cmd_ready_at_release", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("cmd_ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // 4-beat write at 0x0010
    for (i = 0; i < 4; i++) wq[i] = 32'h11111111 * (i + 1);
    send_cmd(1'b1, 16'h0010, 8'd3);
    check("awvalid_after_accept", {31'd0, m_if.awvalid}, 32'd1);
    check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    write_stream(4, 1'b0);
    wait_done("wr4", 1'b0, lat);
    check("wr4_done_latency", lat, 2);
    check("wr4_awaddr", {16'd0, aw_addr_log}, 32'h0010);
    check("wr4_awlen", {24'd0, aw_len_log}, 32'd3);
    check("wr4_awsize", {29'd0, aw_size_log}, 32'd2);
    check("wr4_awburst", {30'd0, aw_burst_log}, 32'd1);

    // Read back 0x0010
    send_cmd(1'b0, 16'h0010, 8'd3);
    check("arvalid_after_accept", {31'd0, m_if.arvalid}, 32'd1);
    read_stream(4, 1'b0, 1'b1);
    wait_done("rd4", 1'b0, lat);
    check("rd4_araddr", {16'd0, ar_addr_log}, 32'h0010);
    check("rd4_arlen", {24'd0, ar_len_log}, 32'd3);

    // Single-beat write/read at 0x0004
    wq[0] = 32'hDEADBEEF;
    send_cmd(1'b1, 16'h0004, 8'd0);
    write_stream(1, 1'b0);
    wait_done("wr1", 1'b0, lat);
    send_cmd(1'b0, 16'h0004, 8'd0);
    read_stream(1, 1'b0, 1'b1);
    wait_done("rd1", 1'b0, lat);

    // Backpressure: toggling wr_valid, rd_ready low 3 cycles per beat
    for (i = 0; i < 6; i++) wq[i] = 32'hB0B00000 + i;
    send_cmd(1'b1, 16'h0100, 8'd5);
    write_stream(6, 1'b1);
    wait_done("wr6_bp", 1'b0, lat);
    send_cmd(1'b0, 16'h0100, 8'd5);
    read_stream(6, 1'b1, 1'b1);
    wait_done("rd6_bp", 1'b0, lat);

    // Slave never raises rlast: burst ends at len with err
    nolast_cfg = 1'b1;
    send_cmd(1'b0, 16'h0100, 8'd2);
    read_stream(3, 1'b0, 1'b0);
    wait_done("rd_nolast", 1'b1, lat);
    nolast_cfg = 1'b0;

    // SLVERR write response, then a clean command clears err
    wq[0] = 32'h0BAD0001; wq[1] = 32'h0BAD0002;
    bresp_cfg = 2'b10;
    send_cmd(1'b1, 16'h0200, 8'd1);
    write_stream(2, 1'b0);
    wait_done("wr_slverr", 1'b1, lat);
    bresp_cfg = 2'b00;
    send_cmd(1'b0, 16'h0200, 8'd1);
    read_stream(2, 1'b0, 1'b1);
    wait_done("rd_after_err", 1'b0, lat);

    // Maximum burst: 256 beats
    for (i = 0; i < 256; i++) wq[i] = 32'hC3000000 + i * 32'h00010001;
    send_cmd(1'b1, 16'h0400, 8'd255);
    write_stream(256, 1'b0);
    wait_done("wr256", 1'b0, lat);
    send_cmd(1'b0, 16'h0400, 8'd255);
    read_stream(256, 1'b0, 1'b1);
    wait_done("rd256", 1'b0, lat);

    // Reset while beat 2 of a write is presented
    for (i = 0; i < 4; i++) wq[i] = 32'h5A5A0000 + i;
    send_cmd(1'b1, 16'h0300, 8'd3);
    i = 0;
    lat = 0;
    wr_valid = 1'b1;
    while (i < 2 && lat < 50) begin
      wr_data = wq[i];
      #1;
      if (wr_ready) i++;
      @(negedge clk);
      lat++;
    end
    wr_data = wq[2];
    #1 check("beat2_presented", {31'd0, m_if.wvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valids", {28'd0, m_if.awvalid, m_if.wvalid, m_if.arvalid, rd_valid}, 32'd0);
    check("midrst_ready_done", {29'd0, cmd_ready, wr_ready, done}, 32'd0);
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_cmd_ready_release", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("midrst_cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
    check("midrst_no_done", done_cycles - done_base, 0);
    wq[0] = 32'h600DF00D; wq[1] = 32'h12345678;
    send_cmd(1'b1, 16'h0300, 8'd1);
    write_stream(2, 1'b0);
    wait_done("wr_after_rst", 1'b0, lat);
    send_cmd(1'b0, 16'h0300, 8'd1);
    read_stream(2, 1'b0, 1'b1);
    wait_done("rd_after_rst", 1'b0, lat);

`ifdef AXI_MASTER_4K_CHECK_EN
    // 0x0FF0 + 8*4 = 0x1010 crosses the page: rejected without AXI traffic
    i = aw_count;
    send_cmd(1'b1, 16'h0FF0, 8'd7);
    check("4k_no_awvalid", {31'd0, m_if.awvalid}, 32'd0);
    wait_done("4k_reject", 1'b1, lat);
    check("4k_no_aw_handshake", aw_count - i, 0);
`endif

    check("no_early_w", early_w, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
